hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_pkg.sv | 12 +
 rtl/hazard_match.sv | 24 ++
 rtl/hazard_ctrl.sv | 141 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared state encoding and default parameters for hazard_ctrl
package hazard_pkg;

  typedef enum logic {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } state_t;

  localparam int REG_AW_DEF   = 5;
  localparam int LOAD_LAT_DEF = 1;

endpackage

// File: rtl/hazard_match.sv
// rtl/hazard_match.sv - load-use source match between ID sources and the load in EX
module hazard_match
  import hazard_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  output logic              hit
);

  logic rs1_match;
  logic rs2_match;

  // x0 is hardwired zero, so a load targeting it never creates a dependency
  assign rs1_match = id_rs1_used && (id_rs1 == ex_rd);
  assign rs2_match = id_rs2_used && (id_rs2 == ex_rd);
  assign hit       = ex_mem_read && (ex_rd != '0) && (rs1_match || rs2_match);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush control; HAZARD_PERF_EN adds saturating perf counters
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW   = REG_AW_DEF,
  parameter int LOAD_LAT = LOAD_LAT_DEF,
  parameter int PERF_W   = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_branch_taken,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_stall,
  output logic              if_id_stall,
  output logic              id_ex_stall,
  output logic              ex_mem_stall,
  output logic              if_id_flush,
  output logic              id_ex_flush
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0] load_stall_cnt,
  output logic [PERF_W-1:0] mem_stall_cnt,
  output logic [PERF_W-1:0] flush_cnt
`endif
);

  localparam logic [3:0] LAT_M1 = 4'(LOAD_LAT - 1);

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic [REG_AW-1:0] pend_rd, pend_rd_nxt;
  logic              hit;
  logic              mem_busy;
  logic              load_stall_cyc;
  logic              mem_stall_cyc;
  logic              flush_cyc;
  logic              unused_pend;

  hazard_match #(.REG_AW(REG_AW)) u_match (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .hit         (hit)
  );

  assign mem_busy    = mem_req && !mem_ready;
  // pend_rd is kept for debug visibility; it does not steer any decision
  assign unused_pend = ^pend_rd;

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    pend_rd_nxt    = pend_rd;
    pc_stall       = 1'b0;
    if_id_stall    = 1'b0;
    id_ex_stall    = 1'b0;
    ex_mem_stall   = 1'b0;
    if_id_flush    = 1'b0;
    id_ex_flush    = 1'b0;
    load_stall_cyc = 1'b0;
    mem_stall_cyc  = 1'b0;
    flush_cyc      = 1'b0;
    if (!reset_n) begin
      state_nxt = IDLE;
    end else if (mem_busy) begin
      pc_stall      = 1'b1;
      if_id_stall   = 1'b1;
      id_ex_stall   = 1'b1;
      ex_mem_stall  = 1'b1;
      mem_stall_cyc = 1'b1;
    end else if (state == LOAD_WAIT) begin
      // the dependent instruction is already held, so a branch here cannot be younger work
      pc_stall       = 1'b1;
      if_id_stall    = 1'b1;
      id_ex_flush    = 1'b1;
      load_stall_cyc = 1'b1;
      cnt_nxt        = cnt - 4'd1;
      if (cnt == 4'd1) state_nxt = IDLE;
    end else if (ex_branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      flush_cyc   = 1'b1;
    end else if (hit) begin
      pc_stall       = 1'b1;
      if_id_stall    = 1'b1;
      id_ex_flush    = 1'b1;
      load_stall_cyc = 1'b1;
      if (LOAD_LAT > 1) begin
        state_nxt   = LOAD_WAIT;
        cnt_nxt     = LAT_M1;
        pend_rd_nxt = ex_rd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      pend_rd <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pend_rd <= pend_rd_nxt;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] load_q, mem_q, flush_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      load_q  <= '0;
      mem_q   <= '0;
      flush_q <= '0;
    end else begin
      if (load_stall_cyc && (load_q != '1)) load_q  <= load_q + 1'b1;
      if (mem_stall_cyc && (mem_q != '1))   mem_q   <= mem_q + 1'b1;
      if (flush_cyc && (flush_q != '1))     flush_q <= flush_q + 1'b1;
    end
  end

  assign load_stall_cnt = reset_n ? load_q  : '0;
  assign mem_stall_cnt  = reset_n ? mem_q   : '0;
  assign flush_cnt      = reset_n ? flush_q : '0;
`else
  logic [PERF_W+2:0] unused_perf;
  assign unused_perf = {{PERF_W{1'b0}}, load_stall_cyc, mem_stall_cyc, flush_cyc};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl at LOAD_LAT=1 and LOAD_LAT=3
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       id_rs1_used = 1'b0, id_rs2_used = 1'b0;
  logic       ex_mem_read = 1'b0, ex_branch_taken = 1'b0;
  logic       mem_req = 1'b0, mem_ready = 1'b1;

  logic pc1, ifs1, ids1, exs1, iff1, idf1;
  logic pc3, ifs3, ids3, exs3, iff3, idf3;
`ifdef HAZARD_PERF_EN
  logic [1:0]  lc1, mc1, fc1;
  logic [31:0] lc3, mc3, fc3;
`endif

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(5), .LOAD_LAT(1), .PERF_W(2)) dut1 (
    .clk(clk), .reset_n(reset_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_stall(pc1), .if_id_stall(ifs1), .id_ex_stall(ids1), .ex_mem_stall(exs1),
    .if_id_flush(iff1), .id_ex_flush(idf1)
`ifdef HAZARD_PERF_EN
    , .load_stall_cnt(lc1), .mem_stall_cnt(mc1), .flush_cnt(fc1)
`endif
  );

  hazard_ctrl #(.REG_AW(5), .LOAD_LAT(3), .PERF_W(32)) dut3 (
    .clk(clk), .reset_n(reset_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_stall(pc3), .if_id_stall(ifs3), .id_ex_stall(ids3), .ex_mem_stall(exs3),
    .if_id_flush(iff3), .id_ex_flush(idf3)
`ifdef HAZARD_PERF_EN
    , .load_stall_cnt(lc3), .mem_stall_cnt(mc3), .flush_cnt(fc3)
`endif
  );

  typedef struct packed {
    logic [5:0]  o1, o3;
    logic [31:0] l1, m1, f1, l3, m3, f3;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_pass = 0;

  // reference model: remaining stall-plus-bubble cycles and saturating event tallies
  int     rem[2];
  int     lat[2] = '{1, 3};
  longint pmax[2] = '{3, 64'hFFFF_FFFF};
  longint lsc[2], msc[2], fsc[2];

  localparam logic [5:0] O_NONE  = 6'b000000;
  localparam logic [5:0] O_LOAD  = 6'b110001;
  localparam logic [5:0] O_BUSY  = 6'b111100;
  localparam logic [5:0] O_FLUSH = 6'b000011;

  task automatic model(input int k, input logic rst, input logic hit, input logic busy,
                       input logic br, output logic [5:0] o,
                       output logic [31:0] l, output logic [31:0] m, output logic [31:0] f);
    l = rst ? 32'(lsc[k]) : 32'd0;
    m = rst ? 32'(msc[k]) : 32'd0;
    f = rst ? 32'(fsc[k]) : 32'd0;
    if (!rst) begin
      o = O_NONE; rem[k] = 0; lsc[k] = 0; msc[k] = 0; fsc[k] = 0;
    end else if (busy) begin
      o = O_BUSY;
      if (msc[k] < pmax[k]) msc[k]++;
    end else if (rem[k] > 0) begin
      o = O_LOAD; rem[k]--;
      if (lsc[k] < pmax[k]) lsc[k]++;
    end else if (br) begin
      o = O_FLUSH;
      if (fsc[k] < pmax[k]) fsc[k]++;
    end else if (hit) begin
      o = O_LOAD; rem[k] = lat[k] - 1;
      if (lsc[k] < pmax[k]) lsc[k]++;
    end else begin
      o = O_NONE;
    end
  endtask

  task automatic step(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic [4:0] rd,
                      input logic mr, input logic br, input logic mreq, input logic mrdy);
    exp_t e;
    logic hit, busy;
    @(posedge clk);
    #1;
    reset_n = rst; id_rs1 = rs1; id_rs2 = rs2; id_rs1_used = u1; id_rs2_used = u2;
    ex_rd = rd; ex_mem_read = mr; ex_branch_taken = br; mem_req = mreq; mem_ready = mrdy;
    hit  = mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    busy = mreq && !mrdy;
    model(0, rst, hit, busy, br, e.o1, e.l1, e.m1, e.f1);
    model(1, rst, hit, busy, br, e.o3, e.l3, e.m3, e.f3);
    sbq.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("lat1_outputs", 32'({pc1, ifs1, ids1, exs1, iff1, idf1}), 32'(e.o1));
        chk("lat3_outputs", 32'({pc3, ifs3, ids3, exs3, iff3, idf3}), 32'(e.o3));
`ifdef HAZARD_PERF_EN
        chk("lat1_load_stall_cnt", 32'(lc1), e.l1);
        chk("lat1_mem_stall_cnt", 32'(mc1), e.m1);
        chk("lat1_flush_cnt", 32'(fc1), e.f1);
        chk("lat3_load_stall_cnt", lc3, e.l3);
        chk("lat3_mem_stall_cnt", mc3, e.m3);
        chk("lat3_flush_cnt", fc3, e.f3);
`endif
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    for (int k = 0; k < 2; k++) begin
      rem[k] = 0; lsc[k] = 0; msc[k] = 0; fsc[k] = 0;
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(2);
    // single load-use hit on rs1
    step(1, 5, 0, 1, 0, 5, 1, 0, 0, 1);
    idle(4);
    // x0 never matches; unused rs2 never matches
    step(1, 0, 0, 1, 0, 0, 1, 0, 0, 1);
    step(1, 0, 7, 0, 0, 7, 1, 0, 0, 1);
    idle(2);
    // hit, then memory busy during the second stall cycle
    step(1, 9, 0, 1, 0, 9, 1, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(4);
    // hit coinciding with a taken branch
    step(1, 6, 0, 1, 0, 6, 1, 1, 0, 1);
    idle(2);
    // reset in the middle of a load wait, then a branch must see IDLE
    step(1, 0, 4, 0, 1, 4, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    idle(1);
    // five flushes saturate a 2-bit counter
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    // back-to-back dependent loads
    step(1, 3, 0, 1, 0, 3, 1, 0, 0, 1);
    step(1, 3, 0, 1, 0, 3, 1, 0, 0, 1);
    step(1, 3, 0, 1, 0, 3, 1, 0, 0, 1);
    step(1, 0, 3, 0, 1, 3, 1, 0, 0, 1);
    idle(3);
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 60) != 0,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom % 2), 1'($urandom % 2), 5'($urandom_range(0, 3)),
           1'($urandom % 2), ($urandom % 8) == 0,
           1'($urandom % 2), ($urandom % 4) != 0);
    end
    idle(1);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
